// File: rtl/three_unshuffler_if.sv
// Stream bundle for the FFT output reorder stage: three input lanes with frame
// marker, three reordered output lanes and the frame-alignment error pulse.
interface three_unshuffler_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         out_valid;
  logic [W-1:0] ao;
  logic [W-1:0] bo;
  logic [W-1:0] co;
  logic         sync_err;

  modport master (
    output in_valid, in_sof, a, b, c,
    input  out_valid, ao, bo, co, sync_err
  );

  modport slave (
    input  in_valid, in_sof, a, b, c,
    output out_valid, ao, bo, co, sync_err
  );
endinterface

// File: rtl/three_unshuffler.sv
// Output reorder stage of the radix-3^2 FFT: 3x3 transpose of lane vs. D-beat group
// per 3*DEPTH-beat frame, built from skewed delay lines around a beat-driven commutator.
module three_unshuffler #(
  parameter int W     = 32,
  parameter int DEPTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  three_unshuffler_if.slave bus
);
  localparam int FRAME = 3 * DEPTH;
  localparam int CW    = $clog2(FRAME);
  localparam int PW    = $clog2(2 * DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [PW-1:0] PRIMED   = PW'(2 * DEPTH);

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic [PW-1:0] prim_q, prim_d;
  logic [1:0]    grp;
  logic [W-1:0]  x0, x1, x2, m0, m1, m2;
  logic [W-1:0]  din1_q  [DEPTH];
  logic [W-1:0]  din1_d  [DEPTH];
  logic [W-1:0]  din2_q  [2*DEPTH];
  logic [W-1:0]  din2_d  [2*DEPTH];
  logic [W-1:0]  dout0_q [2*DEPTH];
  logic [W-1:0]  dout0_d [2*DEPTH];
  logic [W-1:0]  dout1_q [DEPTH];
  logic [W-1:0]  dout1_d [DEPTH];
  logic [W-1:0]  ao_q, ao_d, bo_q, bo_d, co_q, co_d;
  logic          out_valid_q, out_valid_d, sync_err_q, sync_err_d;

  always_comb begin
    // A start-of-frame beat is always group 0, k=0, whatever the counter says.
    cnt_eff = bus.in_sof ? '0 : cnt_q;
    if (cnt_eff < CW'(DEPTH))          grp = 2'd0;
    else if (cnt_eff < CW'(2 * DEPTH)) grp = 2'd1;
    else                               grp = 2'd2;

    x0 = bus.a;
    x1 = din1_q[DEPTH-1];
    x2 = din2_q[2*DEPTH-1];
    // Output lane l takes delayed input lane (grp - l) mod 3.
    case (grp)
      2'd0:    begin m0 = x0; m1 = x2; m2 = x1; end
      2'd1:    begin m0 = x1; m1 = x0; m2 = x2; end
      default: begin m0 = x2; m1 = x1; m2 = x0; end
    endcase

    cnt_d       = cnt_q;
    prim_d      = prim_q;
    din1_d      = din1_q;
    din2_d      = din2_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    ao_d        = ao_q;
    bo_d        = bo_q;
    co_d        = co_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (bus.in_valid) begin
      cnt_d       = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + CW'(1);
      prim_d      = (prim_q == PRIMED) ? prim_q : prim_q + PW'(1);
      out_valid_d = (prim_q == PRIMED);
      sync_err_d  = bus.in_sof && (cnt_q != '0);

      din1_d[0]  = bus.b;
      dout1_d[0] = m1;
      for (int i = 1; i < DEPTH; i++) begin
        din1_d[i]  = din1_q[i-1];
        dout1_d[i] = dout1_q[i-1];
      end
      din2_d[0]  = bus.c;
      dout0_d[0] = m0;
      for (int i = 1; i < 2 * DEPTH; i++) begin
        din2_d[i]  = din2_q[i-1];
        dout0_d[i] = dout0_q[i-1];
      end

      ao_d = dout0_q[2*DEPTH-1];
      bo_d = dout1_q[DEPTH-1];
      co_d = m2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prim_q      <= '0;
      ao_q        <= '0;
      bo_q        <= '0;
      co_q        <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        din1_q[i]  <= '0;
        dout1_q[i] <= '0;
      end
      for (int i = 0; i < 2 * DEPTH; i++) begin
        din2_q[i]  <= '0;
        dout0_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      prim_q      <= prim_d;
      ao_q        <= ao_d;
      bo_q        <= bo_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
    end
  end

  assign bus.ao        = ao_q;
  assign bus.bo        = bo_q;
  assign bus.co        = co_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_three_unshuffler.sv
// Bench for three_unshuffler (DEPTH=2): randomized and patterned frames checked
// against a frame-level transpose model built from the accepted-beat history.
module tb_three_unshuffler;
  localparam int W = 32;
  localparam int D = 2;
  localparam int F = 3 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  three_unshuffler_if #(.W(W)) bus ();
  three_unshuffler #(.W(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: history of accepted beats, their frame position, last misaligned sof.
  logic [W-1:0] ha[$], hb[$], hc[$];
  int           pos_q[$];
  int           nacc, cur_pos, last_break;
  bit           known;
  logic [W-1:0] la, lb, lc;

  function automatic logic [W-1:0] lane_at(int idx, int g);
    if (g == 0) return ha[idx];
    if (g == 1) return hb[idx];
    return hc[idx];
  endfunction

  function automatic logic [W-1:0] pat(int f, int p, int l);
    return 32'(32'h1000 * f + 32'h100 * (p / D) + 32'h10 * l + p % D);
  endfunction

  task automatic model_reset();
    ha.delete(); hb.delete(); hc.delete(); pos_q.delete();
    nacc = 0; cur_pos = 0; last_break = 0;
    known = 1'b1; la = '0; lb = '0; lc = '0;
  endtask

  task automatic beat(input bit v, input bit sof, input logic [W-1:0] xa, xb, xc,
                      output bit e_ov, output bit e_se, output bit e_kn,
                      output logic [W-1:0] ea, eb, ec);
    int p, u, q, fs, g, k;
    @(negedge clk);
    bus.in_valid = v; bus.in_sof = sof; bus.a = xa; bus.b = xb; bus.c = xc;
    @(posedge clk);
    #1;
    e_ov = 1'b0;
    e_se = 1'b0;
    if (v) begin
      p    = sof ? 0 : cur_pos;
      e_se = sof && (cur_pos != 0);
      if (e_se) last_break = nacc;
      e_ov = (nacc >= 2 * D);
      ha.push_back(xa); hb.push_back(xb); hc.push_back(xc); pos_q.push_back(p);
      cur_pos = (p + 1) % F;
      known = 1'b0;
      if (nacc >= 2 * D) begin
        u  = nacc - 2 * D;
        q  = pos_q[u];
        fs = u - q;
        g  = q / D;
        k  = q % D;
        // Out beat (g,k) lane l = in beat (l,k) lane g of the same frame.
        if (fs >= last_break) begin
          la = lane_at(fs + k, g);
          lb = lane_at(fs + D + k, g);
          lc = lane_at(fs + 2 * D + k, g);
          known = 1'b1;
        end
      end
      nacc++;
    end
    e_kn = known; ea = la; eb = lb; ec = lc;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sync_err, bus.ao, bus.bo, bus.co} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b se=%b ao=%h bo=%h co=%h, want all zero",
               bus.out_valid, bus.sync_err, bus.ao, bus.bo, bus.co);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_transpose();
    bit eov, ese, ekn;
    logic [W-1:0] ea, eb, ec;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < F; p++) begin
        beat(1'b1, p == 0, pat(f, p, 0), pat(f, p, 1), pat(f, p, 2), eov, ese, ekn, ea, eb, ec);
        n_checks++;
        if (bus.out_valid !== eov || bus.sync_err !== ese) begin
          n_fail++;
          $display("FAIL transpose_ctl f%0d p%0d: got ov=%b se=%b, want ov=%b se=%b",
                   f, p, bus.out_valid, bus.sync_err, eov, ese);
        end
        if (ekn) begin
          n_checks++;
          if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
            n_fail++;
            $display("FAIL transpose_data f%0d p%0d: got %h %h %h, want %h %h %h",
                     f, p, bus.ao, bus.bo, bus.co, ea, eb, ec);
          end
        end
        if (f == 0 && p == 2 * D) begin
          n_checks++;
          if ({bus.out_valid, bus.ao, bus.bo, bus.co} !== {1'b1, 32'h0, 32'h100, 32'h200}) begin
            n_fail++;
            $display("FAIL first_output: got ov=%b %h %h %h, want 1 00000000 00000100 00000200",
                     bus.out_valid, bus.ao, bus.bo, bus.co);
          end
        end
      end
    end
  endtask

  task automatic test_stalls();
    bit eov, ese, ekn, v;
    logic [W-1:0] ea, eb, ec;
    int p;
    for (int f = 3; f < 6; f++) begin
      p = 0;
      while (p < F) begin
        v = ($urandom_range(0, 2) != 0);
        if (v) beat(1'b1, p == 0, pat(f, p, 0), pat(f, p, 1), pat(f, p, 2), eov, ese, ekn, ea, eb, ec);
        else   beat(1'b0, 1'b1, $urandom(), $urandom(), $urandom(), eov, ese, ekn, ea, eb, ec);
        n_checks++;
        if (bus.out_valid !== eov || bus.sync_err !== ese) begin
          n_fail++;
          $display("FAIL stall_ctl f%0d p%0d v%b: got ov=%b se=%b, want ov=%b se=%b",
                   f, p, v, bus.out_valid, bus.sync_err, eov, ese);
        end
        if (ekn) begin
          n_checks++;
          if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
            n_fail++;
            $display("FAIL stall_data f%0d p%0d v%b: got %h %h %h, want %h %h %h",
                     f, p, v, bus.ao, bus.bo, bus.co, ea, eb, ec);
          end
        end
        if (v) p++;
      end
    end
  endtask

  task automatic test_sync();
    bit eov, ese, ekn, sof;
    logic [W-1:0] ea, eb, ec;
    // sof at beats 0 and 3, then two clean frames; beat 3 is the misaligned one.
    for (int i = 0; i < 3 + 2 * F; i++) begin
      sof = (i == 0) || (i == 3) || (i == 3 + F);
      beat(1'b1, sof, $urandom(), $urandom(), $urandom(), eov, ese, ekn, ea, eb, ec);
      if (i == 3 || i == 4) begin
        n_checks++;
        if (bus.sync_err !== (i == 3)) begin
          n_fail++;
          $display("FAIL sync_pulse beat %0d: got se=%b, want %b", i, bus.sync_err, i == 3);
        end
      end
      n_checks++;
      if (bus.out_valid !== eov || bus.sync_err !== ese) begin
        n_fail++;
        $display("FAIL sync_ctl beat %0d: got ov=%b se=%b, want ov=%b se=%b",
                 i, bus.out_valid, bus.sync_err, eov, ese);
      end
      if (ekn) begin
        n_checks++;
        if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
          n_fail++;
          $display("FAIL sync_data beat %0d: got %h %h %h, want %h %h %h",
                   i, bus.ao, bus.bo, bus.co, ea, eb, ec);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit eov, ese, ekn;
    logic [W-1:0] ea, eb, ec;
    for (int i = 0; i < 4 * F; i++) begin
      beat(1'b1, i == 0, $urandom(), $urandom(), $urandom(), eov, ese, ekn, ea, eb, ec);
      n_checks++;
      if (bus.out_valid !== eov || bus.sync_err !== ese) begin
        n_fail++;
        $display("FAIL wrap_ctl beat %0d: got ov=%b se=%b, want ov=%b se=%b",
                 i, bus.out_valid, bus.sync_err, eov, ese);
      end
      if (ekn) begin
        n_checks++;
        if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
          n_fail++;
          $display("FAIL wrap_data beat %0d: got %h %h %h, want %h %h %h",
                   i, bus.ao, bus.bo, bus.co, ea, eb, ec);
        end
      end
    end
  endtask

  task automatic test_random();
    bit eov, ese, ekn, v, sof_ok, early;
    logic [W-1:0] ea, eb, ec;
    int p;
    for (int f = 0; f < 150; f++) begin
      sof_ok = ($urandom_range(0, 3) != 0);
      early  = ($urandom_range(0, 19) == 0);
      p = 0;
      while (p < F) begin
        v = ($urandom_range(0, 3) != 0);
        beat(v, v && ((p == 0 && sof_ok) || (p == 2 && early)), $urandom(), $urandom(), $urandom(),
             eov, ese, ekn, ea, eb, ec);
        n_checks++;
        if (bus.out_valid !== eov || bus.sync_err !== ese) begin
          n_fail++;
          $display("FAIL random_ctl f%0d p%0d: got ov=%b se=%b, want ov=%b se=%b",
                   f, p, bus.out_valid, bus.sync_err, eov, ese);
        end
        if (ekn) begin
          n_checks++;
          if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
            n_fail++;
            $display("FAIL random_data f%0d p%0d: got %h %h %h, want %h %h %h",
                     f, p, bus.ao, bus.bo, bus.co, ea, eb, ec);
          end
        end
        if (v) p++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit eov, ese, ekn;
    logic [W-1:0] ea, eb, ec;
    for (int i = 0; i < F + 3; i++)
      beat(1'b1, i == 0, $urandom(), $urandom(), $urandom(), eov, ese, ekn, ea, eb, ec);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sync_err, bus.ao, bus.bo, bus.co} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got ov=%b se=%b ao=%h bo=%h co=%h, want all zero",
               bus.out_valid, bus.sync_err, bus.ao, bus.bo, bus.co);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * F; i++) begin
      beat(1'b1, 1'b0, $urandom(), $urandom(), $urandom(), eov, ese, ekn, ea, eb, ec);
      if (i < 2 * D + 1) begin
        n_checks++;
        if (bus.out_valid !== (i == 2 * D)) begin
          n_fail++;
          $display("FAIL post_reset_prime beat %0d: got ov=%b, want %b", i, bus.out_valid, i == 2 * D);
        end
      end
      if (ekn) begin
        n_checks++;
        if ({bus.ao, bus.bo, bus.co} !== {ea, eb, ec}) begin
          n_fail++;
          $display("FAIL post_reset_data beat %0d: got %h %h %h, want %h %h %h",
                   i, bus.ao, bus.bo, bus.co, ea, eb, ec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_stalls();
    test_sync();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
